// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port: grants the core
// or the debug/loader port, holds the latched access for WAIT cycles, then acks.
module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic            owner_r;       // 1 = debug port owns the current transfer
  logic            last_grant_r;  // 1 = debug port won the most recent grant
  logic            lat_we_r;
  logic [AW-1:0]   lat_addr_r;
  logic [DW-1:0]   lat_wdata_r;
  logic [DW-1:0]   cpu_rdata_r;
  logic [DW-1:0]   dbg_rdata_r;
  logic            grant_s;
  logic            grant_dbg_s;
  logic            capture_s;

  // Next-state, grant selection and read-capture decode
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    grant_dbg_s = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req && dbg_req) begin
          grant_s     = 1'b1;
          grant_dbg_s = ~last_grant_r;
          state_nxt_s = ACCESS;
        end else if (cpu_req) begin
          grant_s     = 1'b1;
          grant_dbg_s = 1'b0;
          state_nxt_s = ACCESS;
        end else if (dbg_req) begin
          grant_s     = 1'b1;
          grant_dbg_s = 1'b1;
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == CNT_ZERO) begin
          capture_s   = ~lat_we_r;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        cnt_r <= CNT_LOAD;
      end else if (state_r == ACCESS && cnt_r != CNT_ZERO) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Request latch: requester inputs are only sampled at the grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      lat_we_r     <= 1'b0;
      lat_addr_r   <= {AW{1'b0}};
      lat_wdata_r  <= {DW{1'b0}};
    end else if (grant_s) begin
      owner_r      <= grant_dbg_s;
      last_grant_r <= grant_dbg_s;
      lat_we_r     <= grant_dbg_s ? dbg_we    : cpu_we;
      lat_addr_r   <= grant_dbg_s ? dbg_addr  : cpu_addr;
      lat_wdata_r  <= grant_dbg_s ? dbg_wdata : cpu_wdata;
    end
  end

  // Per-owner read data, updated only by that owner's reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata_r <= {DW{1'b0}};
      dbg_rdata_r <= {DW{1'b0}};
    end else if (capture_s) begin
      if (owner_r) begin
        dbg_rdata_r <= mem_rdata;
      end else begin
        cpu_rdata_r <= mem_rdata;
      end
    end
  end

  // Outputs decode only from registered state, so reset clears them asynchronously
  assign mem_en    = (state_r == ACCESS);
  assign mem_we    = (state_r == ACCESS) & lat_we_r;
  assign mem_addr  = lat_addr_r;
  assign mem_wdata = lat_wdata_r;
  assign cpu_ack   = (state_r == DONE) & ~owner_r;
  assign dbg_ack   = (state_r == DONE) & owner_r;
  assign cpu_rdata = cpu_rdata_r;
  assign dbg_rdata = dbg_rdata_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a WAIT=2 instance for reads, writes,
// contention and mid-transfer reset, and a WAIT=1 instance for back-to-back reads.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, busy;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  // Fixed memory contents for the WAIT=2 instance
  assign mem_rdata = (mem_addr == 32'h0000_0040) ? 32'hDEAD_BEEF :
                     (mem_addr == 32'h0000_0020) ? 32'hCAFE_F00D : 32'h0000_0000;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(2)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  logic        w1_req, w1_we, w1_dreq, w1_dwe;
  logic [31:0] w1_addr, w1_wdata, w1_daddr, w1_dwdata;
  logic        w1_ack, w1_dack, w1_en, w1_mwe, w1_busy;
  logic [31:0] w1_rdata, w1_drdata, w1_maddr, w1_mwdata, w1_mrdata;

  // WAIT=1 instance memory returns a pattern derived from the address
  assign w1_mrdata = w1_maddr ^ 32'hC0DE_0000;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(w1_req), .cpu_we(w1_we), .cpu_addr(w1_addr), .cpu_wdata(w1_wdata),
    .cpu_ack(w1_ack), .cpu_rdata(w1_rdata),
    .dbg_req(w1_dreq), .dbg_we(w1_dwe), .dbg_addr(w1_daddr), .dbg_wdata(w1_dwdata),
    .dbg_ack(w1_dack), .dbg_rdata(w1_drdata),
    .mem_en(w1_en), .mem_we(w1_mwe), .mem_addr(w1_maddr), .mem_wdata(w1_mwdata),
    .mem_rdata(w1_mrdata), .busy(w1_busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wcnt, wgood, ackcnt;
    logic [31:0] a1;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    w1_req = 1'b0; w1_we = 1'b0; w1_addr = 32'h0; w1_wdata = 32'h0;
    w1_dreq = 1'b0; w1_dwe = 1'b0; w1_daddr = 32'h0; w1_dwdata = 32'h0;
    #2;
    chk("rst_mem_en", mem_en, 32'd0);
    chk("rst_mem_we", mem_we, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {cpu_ack, dbg_ack}, 32'd0);
    chk("rst_rdata", cpu_rdata | dbg_rdata, 32'd0);
    chk("rst_busy", busy, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // CPU read at 0x40; address changes after the grant must be ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
    tick();
    chk("rd_c1_en", mem_en, 32'd1);
    chk("rd_c1_addr", mem_addr, 32'h0000_0040);
    chk("rd_c1_busy", busy, 32'd1);
    cpu_addr = 32'h0000_0080;
    tick();
    chk("rd_c2_en", mem_en, 32'd1);
    chk("rd_c2_addr", mem_addr, 32'h0000_0040);
    chk("rd_c2_we", mem_we, 32'd0);
    chk("rd_c2_ack", cpu_ack, 32'd0);
    tick();
    chk("rd_c3_ack", cpu_ack, 32'd1);
    chk("rd_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_c3_en", mem_en, 32'd0);
    chk("rd_c3_dack", dbg_ack, 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("rd_c4_busy", busy, 32'd0);
    chk("rd_c4_ack", cpu_ack, 32'd0);
    chk("rd_c4_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Debug write: mem_we for exactly WAIT cycles, a single ack
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0000_0010; dbg_wdata = 32'h1234_5678;
    wcnt = 0; wgood = 0; ackcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_we) wcnt++;
      if (mem_we && mem_en && mem_addr == 32'h0000_0010 && mem_wdata == 32'h1234_5678) wgood++;
      if (dbg_ack) begin
        ackcnt++;
        dbg_req = 1'b0;
      end
      if (cpu_ack) ackcnt = ackcnt + 100;
    end
    chk("wr_we_cycles", wcnt, 32'd2);
    chk("wr_we_values", wgood, 32'd2);
    chk("wr_ack_count", ackcnt, 32'd1);
    chk("wr_dbg_rdata", dbg_rdata, 32'd0);
    chk("wr_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    dbg_we = 1'b0;

    // Reset in the second ACCESS cycle of a CPU read
    cpu_req = 1'b1; cpu_addr = 32'h0000_0040;
    tick();
    tick();
    chk("mr_pre_en", mem_en, 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_en", mem_en, 32'd0);
    chk("mr_we", mem_we, 32'd0);
    chk("mr_busy", busy, 32'd0);
    chk("mr_addr", mem_addr, 32'd0);
    chk("mr_rdata", cpu_rdata, 32'd0);
    chk("mr_ack", {cpu_ack, dbg_ack}, 32'd0);
    tick();
    chk("mr_ack_held", {cpu_ack, dbg_ack}, 32'd0);

    // Contention from reset: cpu, dbg, cpu, dbg with acks WAIT+2 apart
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0000_0020;
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) chk("ct_regrant_addr", mem_addr, 32'h0000_0040);
      chk($sformatf("ct_cpu_ack_%0d", i), cpu_ack, {31'd0, (i == 3 || i == 11)});
      chk($sformatf("ct_dbg_ack_%0d", i), dbg_ack, {31'd0, (i == 7 || i == 15)});
      if (i == 3 || i == 11) chk("ct_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      if (i == 7 || i == 15) chk("ct_dbg_rdata", dbg_rdata, 32'hCAFE_F00D);
      if (i == 15) begin
        cpu_req = 1'b0;
        dbg_req = 1'b0;
      end
    end
    tick();
    chk("ct_idle_busy", busy, 32'd0);

    // WAIT=1: back-to-back CPU reads, ack every third cycle
    a1 = 32'h0000_0040;
    w1_req = 1'b1; w1_addr = a1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("w1_ack_%0d", i), w1_ack, {31'd0, (i % 3 == 2)});
      if (i % 3 == 1) chk("w1_en", w1_en, 32'd1);
      if (w1_ack) begin
        chk("w1_rdata", w1_rdata, a1 ^ 32'hC0DE_0000);
        a1 = a1 + 32'd4;
        w1_addr = a1;
      end
    end
    w1_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
